// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one 1-cycle-latency sprite ROM
// among NUM_REQ renderers. Each grant fetches one full row of words, streams
// them tagged with owner id and word index, then pulses done to the owner.
module sprite_rom_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ROW_BITS   = 4,
    parameter int WORD_BITS  = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ROW_BITS-1:0]   req_row,
    output logic [NUM_REQ-1:0]            done,
    output logic                          busy,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [15:0]                   rom_dout,
    output logic                          out_valid,
    output logic [15:0]                   out_data,
    output logic [$clog2(NUM_REQ)-1:0]    out_id,
    output logic [WORD_BITS-1:0]          out_word
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t               state;
    logic [ID_W-1:0]      rr_last;
    logic [ID_W-1:0]      grant_id;
    logic [ROW_BITS-1:0]  row_q;
    logic [WORD_BITS-1:0] word_cnt;

    logic                 pick_ok;
    logic [ID_W-1:0]      pick_id;

    // Round-robin pick: first asserted request after the last winner.
    always_comb begin
        int idx;
        idx     = 0;
        pick_ok = 1'b0;
        pick_id = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_last) + k) % NUM_REQ;
            if (!pick_ok && req[idx]) begin
                pick_ok = 1'b1;
                pick_id = ID_W'(idx);
            end
        end
    end

    // word_cnt is zero outside ISSUE, so the address holds {row_q, 0} there.
    assign rom_addr = {row_q, word_cnt};
    assign out_data = rom_dout;
    assign busy     = (state != IDLE);

    // Fetch sequencer plus the output tags delayed one cycle to line up with
    // the ROM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_last   <= ID_W'(NUM_REQ - 1);
            grant_id  <= '0;
            row_q     <= '0;
            word_cnt  <= '0;
            done      <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_word  <= '0;
        end else begin
            done      <= '0;
            out_valid <= (state == ISSUE);
            out_id    <= grant_id;
            out_word  <= word_cnt;
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        grant_id <= pick_id;
                        rr_last  <= pick_id;
                        row_q    <= req_row[pick_id*ROW_BITS +: ROW_BITS];
                        word_cnt <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (word_cnt == {WORD_BITS{1'b1}}) begin
                        // Last address issued: its word lands next cycle,
                        // together with the done pulse.
                        word_cnt       <= '0;
                        done[grant_id] <= 1'b1;
                        state          <= DRAIN;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                DRAIN:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: ROM model, output-stream scoreboard and
// per-scenario tasks checking addresses, busy and done timing.
module tb_sprite_rom_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [11:0] req_row;
    logic [2:0]  done;
    logic        busy;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  out_id;
    logic [3:0]  out_word;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  id;
        logic [3:0]  word;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    sprite_rom_arbiter #(.NUM_REQ(3), .ROW_BITS(4), .WORD_BITS(4), .ADDR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .req(req), .req_row(req_row), .done(done),
        .busy(busy), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_word(out_word)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_img(input logic [7:0] a);
        return {a ^ 8'hA5, ~a};
    endfunction

    // Registered ROM, one-cycle read latency.
    always @(posedge clk) rom_dout <= rom_img(rom_addr);

    // Scoreboard: every valid output word must match the next expected word.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_extra: got id=%0d word=%0d data=%h, expected no word",
                         out_id, out_word, out_data);
            end else begin
                e = sb.pop_front();
                if (out_id !== e.id || out_word !== e.word || out_data !== e.data) begin
                    failures++;
                    $display("FAIL sb_word: got id=%0d word=%0d data=%h, expected id=%0d word=%0d data=%h",
                             out_id, out_word, out_data, e.id, e.word, e.data);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [1:0] id, input logic [3:0] row);
        exp_t x;
        for (int w = 0; w < 16; w++) begin
            x.id   = id;
            x.word = 4'(w);
            x.data = rom_img({row, 4'(w)});
            sb.push_back(x);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        req_row = '0;
        step();
        step();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 3'b000 || out_valid !== 1'b0 || out_id !== 2'd0 ||
            out_word !== 4'd0 || rom_addr !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b ov=%b id=%0d word=%0d addr=%h, expected all 0",
                     busy, done, out_valid, out_id, out_word, rom_addr);
        end
    endtask

    task automatic test_single();
        logic [7:0] ea;
        do_reset();
        req_row[3:0] = 4'h5;
        req          = 3'b001;
        push_fetch(2'd0, 4'h5);
        for (int s = 0; s < 20; s++) begin
            step();
            ea = (s <= 15) ? 8'(8'h50 + s) : 8'h50;
            checks++;
            if (rom_addr !== ea) begin
                failures++;
                $display("FAIL single_addr s=%0d: got %h expected %h", s, rom_addr, ea);
            end
            checks++;
            if (busy !== (s <= 16)) begin
                failures++;
                $display("FAIL single_busy s=%0d: got %b expected %b", s, busy, (s <= 16));
            end
            checks++;
            if (out_valid !== (s >= 1 && s <= 16)) begin
                failures++;
                $display("FAIL single_valid s=%0d: got %b", s, out_valid);
            end
            checks++;
            if (done !== ((s == 16) ? 3'b001 : 3'b000)) begin
                failures++;
                $display("FAIL single_done s=%0d: got %b", s, done);
            end
            if (s == 16) req = '0;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL single_sb_left: got %0d words left expected 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        int         ord[4] = '{0, 1, 2, 0};
        logic [3:0] rows[3] = '{4'h1, 4'h2, 4'h3};
        logic [2:0] ed;
        do_reset();
        req_row = {4'h3, 4'h2, 4'h1};
        req     = 3'b111;
        for (int k = 0; k < 4; k++) push_fetch(2'(ord[k]), rows[ord[k]]);
        for (int s = 0; s < 74; s++) begin
            step();
            ed = 3'b000;
            if (s >= 16 && (s - 16) % 18 == 0 && (s - 16) / 18 < 4)
                ed = 3'b001 << ord[(s - 16) / 18];
            checks++;
            if (done !== ed) begin
                failures++;
                $display("FAIL rr_done s=%0d: got %b expected %b", s, done, ed);
            end
            if (s % 18 == 0 && s / 18 < 4) begin
                checks++;
                if (rom_addr !== {rows[ord[s / 18]], 4'h0}) begin
                    failures++;
                    $display("FAIL rr_addr s=%0d: got %h expected %h", s, rom_addr,
                             {rows[ord[s / 18]], 4'h0});
                end
            end
            if (s == 70) req = '0;
        end
        checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rr_end: got %0d words left busy=%b expected 0/0", sb.size(), busy);
        end
    endtask

    task automatic test_mid_request();
        logic [2:0] ed;
        do_reset();
        req_row[7:4] = 4'h4;
        req          = 3'b010;
        push_fetch(2'd1, 4'h4);
        push_fetch(2'd0, 4'h6);
        for (int s = 0; s < 38; s++) begin
            step();
            ed = (s == 16) ? 3'b010 : (s == 34) ? 3'b001 : 3'b000;
            checks++;
            if (done !== ed) begin
                failures++;
                $display("FAIL mid_done s=%0d: got %b expected %b", s, done, ed);
            end
            if (s == 0 || s == 18) begin
                checks++;
                if (rom_addr !== ((s == 0) ? 8'h40 : 8'h60)) begin
                    failures++;
                    $display("FAIL mid_addr s=%0d: got %h", s, rom_addr);
                end
            end
            if (s == 5) begin
                req[0]       = 1'b1;
                req_row[3:0] = 4'h6;
            end
            if (s == 16) req[1] = 1'b0;
            if (s == 34) req[0] = 1'b0;
        end
        checks++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_end: got %0d words left busy=%b expected 0/0", sb.size(), busy);
        end
    endtask

    task automatic test_row_change();
        do_reset();
        req_row[3:0] = 4'h7;
        req          = 3'b001;
        push_fetch(2'd0, 4'h7);
        for (int s = 0; s < 19; s++) begin
            step();
            if (s <= 15) begin
                checks++;
                if (rom_addr !== 8'(8'h70 + s)) begin
                    failures++;
                    $display("FAIL rowchg_addr s=%0d: got %h expected %h", s, rom_addr, 8'(8'h70 + s));
                end
            end
            if (s == 3) req_row[3:0] = 4'h9;
            if (s == 16) req = '0;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL rowchg_sb_left: got %0d expected 0", sb.size());
        end
    endtask

    task automatic test_abort();
        do_reset();
        req_row[3:0] = 4'h2;
        req          = 3'b001;
        push_fetch(2'd0, 4'h2);
        for (int s = 0; s < 28; s++) begin
            step();
            if (s == 7) begin
                checks++;
                if (out_valid !== 1'b1 || out_word !== 4'd6) begin
                    failures++;
                    $display("FAIL abort_pre: got ov=%b word=%0d expected 1/6", out_valid, out_word);
                end
                reset = 1'b1;
                sb.delete();
            end
            if (s == 8) begin
                checks++;
                if (out_valid !== 1'b0 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_post: got ov=%b busy=%b expected 0/0", out_valid, busy);
                end
                reset = 1'b0;
                push_fetch(2'd0, 4'h2);
            end
            if (s == 9) begin
                checks++;
                if (rom_addr !== 8'h20 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL abort_restart: got addr=%h busy=%b expected 20/1", rom_addr, busy);
                end
            end
            checks++;
            if (done !== ((s == 25) ? 3'b001 : 3'b000)) begin
                failures++;
                $display("FAIL abort_done s=%0d: got %b", s, done);
            end
            if (s == 25) req = '0;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL abort_sb_left: got %0d expected 0", sb.size());
        end
    endtask

    task automatic test_drop_after_grant();
        do_reset();
        req_row[3:0] = 4'hA;
        req          = 3'b001;
        push_fetch(2'd0, 4'hA);
        for (int s = 0; s < 22; s++) begin
            step();
            if (s == 0) req = '0;
            checks++;
            if (done !== ((s == 16) ? 3'b001 : 3'b000)) begin
                failures++;
                $display("FAIL drop_done s=%0d: got %b", s, done);
            end
            checks++;
            if (busy !== (s <= 16)) begin
                failures++;
                $display("FAIL drop_busy s=%0d: got %b expected %b", s, busy, (s <= 16));
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drop_sb_left: got %0d expected 0", sb.size());
        end
    endtask

    initial begin
        reset   = 1'b1;
        req     = '0;
        req_row = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_mid_request();
        test_row_change();
        test_abort();
        test_drop_after_grant();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
